gray_stream_ctrl: RTL

//  Stream sequencer for the pipelined grayscale datapath (r/4+g/2+b/4, 2 regs, no stall).

---
 rtl/gray_stream_ctrl.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/gray_stream_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : gray_stream_ctrl
// Description : Credit-based stream sequencer for the pipelined grayscale
//               datapath, with tag pipe, show-ahead output FIFO and raster
//               end-of-line / end-of-frame markers.
// Revision    : 1.0 - initial release
// ============================================================================
module gray_stream_ctrl #(
  parameter int DATA_W     = 12,
  parameter int PIPE_LAT   = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_g,
  input  logic [DATA_W-1:0] in_b,
  output logic [DATA_W-1:0] gs_r,
  output logic [DATA_W-1:0] gs_g,
  output logic [DATA_W-1:0] gs_b,
  input  logic [DATA_W-1:0] gs_gray,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_gray,
  output logic              out_eol,
  output logic              out_eof,
  output logic              busy
);

  // Stage 0 rides with the gs registers; stages 1..PIPE_LAT+1 track the
  // datapath input registers and its PIPE_LAT pipeline registers.
  localparam int c_TAG_N = PIPE_LAT + 2;
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH + c_TAG_N + 1);
  localparam int c_X_W   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int c_Y_W   = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  logic                w_accept;
  logic                w_push;
  logic                w_pop;
  logic                w_tag_eol;
  logic                w_tag_eof;
  logic [c_CNT_W-1:0]  w_inflight;
  logic [c_CNT_W-1:0]  w_credit;

  logic [c_TAG_N-1:0]  r_tag_v;
  logic [c_TAG_N-1:0]  r_tag_eol;
  logic [c_TAG_N-1:0]  r_tag_eof;

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_mem_eol;
  logic [FIFO_DEPTH-1:0] r_mem_eof;
  logic [c_PTR_W-1:0]  r_wr_ptr;
  logic [c_PTR_W-1:0]  r_rd_ptr;
  logic [c_CNT_W-1:0]  r_fifo_cnt;

  logic [c_X_W-1:0]    r_x;
  logic [c_Y_W-1:0]    r_y;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < c_TAG_N; i++) begin
      w_inflight = w_inflight + c_CNT_W'(r_tag_v[i]);
    end
  end

  // The same-cycle pop is deliberately not credited back.
  assign w_credit = r_fifo_cnt + w_inflight;
  assign in_ready = ~rst & (w_credit < c_CNT_W'(FIFO_DEPTH));
  assign w_accept = in_valid & in_ready;

  assign w_tag_eol = (r_x == c_X_W'(IMG_W - 1));
  assign w_tag_eof = w_tag_eol & (r_y == c_Y_W'(IMG_H - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gs_r <= '0;
      gs_g <= '0;
      gs_b <= '0;
    end else if (w_accept) begin
      gs_r <= in_r;
      gs_g <= in_g;
      gs_b <= in_b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tag_v   <= '0;
      r_tag_eol <= '0;
      r_tag_eof <= '0;
    end else begin
      r_tag_v   <= {r_tag_v[c_TAG_N-2:0],   w_accept};
      r_tag_eol <= {r_tag_eol[c_TAG_N-2:0], w_accept & w_tag_eol};
      r_tag_eof <= {r_tag_eof[c_TAG_N-2:0], w_accept & w_tag_eof};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_accept) begin
      if (w_tag_eol) begin
        r_x <= '0;
        r_y <= w_tag_eof ? '0 : r_y + c_Y_W'(1);
      end else begin
        r_x <= r_x + c_X_W'(1);
      end
    end
  end

  assign w_push    = r_tag_v[c_TAG_N-1];
  assign out_valid = (r_fifo_cnt != '0);
  assign w_pop     = out_valid & out_ready;

  // Gray storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= gs_gray;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_eol  <= '0;
      r_mem_eof  <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
    end else begin
      if (w_push) begin
        r_mem_eol[r_wr_ptr] <= r_tag_eol[c_TAG_N-1];
        r_mem_eof[r_wr_ptr] <= r_tag_eof[c_TAG_N-1];
        r_wr_ptr            <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + c_CNT_W'(1);
        2'b01:   r_fifo_cnt <= r_fifo_cnt - c_CNT_W'(1);
        default: r_fifo_cnt <= r_fifo_cnt;
      endcase
    end
  end

  assign out_gray = out_valid ? r_mem[r_rd_ptr] : '0;
  assign out_eol  = out_valid & r_mem_eol[r_rd_ptr];
  assign out_eof  = out_valid & r_mem_eof[r_rd_ptr];
  assign busy     = (|r_tag_v) | out_valid;

endmodule
`default_nettype wire
